// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: sequences one logic-analyzer capture into a circular RAM around a trigger,
// reporting trigger/oldest-sample addresses and a one-cycle finished pulse.
module la_capture_ctrl #(
    parameter int CH_W   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [CH_W-1:0]   probe,
    input  logic [CH_W-1:0]   trig_mask,
    input  logic [CH_W-1:0]   trig_value,
    input  logic              force_trig,
    input  logic [ADDR_W-1:0] pre_depth,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CH_W-1:0]   ram_wdata,
    output logic              busy,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] base_addr,
    output logic              finished
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, FILL, TRIG, POST, DONE} state_t;

    state_t            state_q, state_d;
    logic              start_prev_q, start_prev_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, pre_q, pre_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d, base_addr_q, base_addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [CH_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc, post_n;
    logic              triggered_q, triggered_d, ram_we_q, ram_we_d, finished_q, finished_d;
    logic              accept, hit;

    assign accept  = sample_en && (state_q == FILL || state_q == TRIG || state_q == POST);
    assign hit     = (((probe ^ trig_value) & trig_mask) == '0) || force_trig;
    assign cnt_inc = cnt_q + (ADDR_W+1)'(1);
    assign post_n  = (ADDR_W+1)'(DEPTH) - {1'b0, pre_q};

    always_comb begin
        state_d      = state_q;
        start_prev_d = start;
        ptr_d        = ptr_q;
        pre_d        = pre_q;
        cnt_d        = cnt_q;
        triggered_d  = triggered_q;
        trig_addr_d  = trig_addr_q;
        base_addr_d  = base_addr_q;
        ram_we_d     = accept;
        ram_addr_d   = accept ? ptr_q : ram_addr_q;
        ram_wdata_d  = accept ? probe : ram_wdata_q;
        finished_d   = 1'b0;
        if (accept) ptr_d = ptr_q + ADDR_W'(1);
        case (state_q)
            IDLE: begin
                if (start && !start_prev_q) begin
                    ptr_d       = '0;
                    pre_d       = pre_depth;
                    cnt_d       = '0;
                    triggered_d = 1'b0;
                    state_d     = (pre_depth == '0) ? TRIG : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    cnt_d   = (cnt_inc == {1'b0, pre_q}) ? '0 : cnt_inc;
                    state_d = (cnt_inc == {1'b0, pre_q}) ? TRIG : FILL;
                end
            end
            TRIG: begin
                if (accept && hit) begin
                    triggered_d = 1'b1;
                    trig_addr_d = ptr_q;
                    base_addr_d = ptr_q - pre_q;
                    cnt_d       = (ADDR_W+1)'(1);
                    state_d     = (post_n == (ADDR_W+1)'(1)) ? DONE : POST;
                end
            end
            POST: begin
                if (accept) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == post_n) ? DONE : POST;
                end
            end
            DONE: begin
                finished_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort wins over a same-cycle trigger or completion; an accepted write still lands
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            finished_d  = 1'b0;
            triggered_d = triggered_q;
            trig_addr_d = trig_addr_q;
            base_addr_d = base_addr_q;
        end
    end

    // start_prev resets high so a start already asserted across reset is not taken as an edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            ptr_q        <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
            triggered_q  <= 1'b0;
            trig_addr_q  <= '0;
            base_addr_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            ptr_q        <= ptr_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            triggered_q  <= triggered_d;
            trig_addr_q  <= trig_addr_d;
            base_addr_q  <= base_addr_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            finished_q   <= finished_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;
    assign base_addr = base_addr_q;
    assign finished  = finished_q;
endmodule
